// File: rtl/s27_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s27_scan_pkg
// Description : Shared constants for the scan-inserted s27 benchmark.
//               CHAIN_LEN          - number of flops on the scan chain
//               RST_STATE_DEFAULT  - default reset value of {G5,G6,G7}
// Revision    : 1.0 - initial release
// ============================================================================
package s27_scan_pkg;

  localparam int         CHAIN_LEN         = 3;
  localparam logic [2:0] RST_STATE_DEFAULT = 3'b000;

endpackage : s27_scan_pkg
`default_nettype wire

// File: rtl/s27_scan_dff.sv
`default_nettype none
// ============================================================================
// Module      : s27_scan_dff
// Description : Mux-D scan flop. SE selects between functional data (D) and
//               scan data (SI); the result is captured on the rising clock
//               edge. Asynchronous active-high reset loads RST_VAL.
// Ports       : ck_i  - clock
//               rst_i - asynchronous active-high reset
//               se_i  - scan enable (1 = shift, 0 = functional)
//               si_i  - scan data in
//               d_i   - functional data in
//               q_o   - registered output
// Revision    : 1.0 - initial release
// ============================================================================
module s27_scan_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ck_i,
  input  logic rst_i,
  input  logic se_i,
  input  logic si_i,
  input  logic d_i,
  output logic q_o
);

  logic w_d;
  logic r_q;

  // SE is only looked at through this mux, so it acts as a plain select
  // sampled at the edge; SI is fully blocked while SE=0.
  assign w_d = se_i ? si_i : d_i;

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_d;
    end
  end

  assign q_o = r_q;

endmodule : s27_scan_dff
`default_nettype wire

// File: rtl/s27_scan.sv
`default_nettype none
// ============================================================================
// Module      : s27_scan
// Description : ISCAS'89 s27 with its three flops stitched into a mux-D scan
//               chain SI -> G5 -> G6 -> G7 (G7 doubles as scan-out).
// Ports       : CK  - clock, rising-edge capture
//               RST - asynchronous active-high reset, loads RST_STATE
//               G0..G3 - functional primary inputs
//               SI  - scan in (feeds G5)
//               SE  - scan enable (1 = shift, 0 = functional capture)
//               G17 - combinational primary output
//               G7  - scan out, straight from flop G7
// Revision    : 1.0 - initial release
// ============================================================================
module s27_scan
  import s27_scan_pkg::*;
#(
  parameter logic [2:0] RST_STATE = RST_STATE_DEFAULT
) (
  input  logic CK,
  input  logic RST,
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  input  logic SI,
  input  logic SE,
  output logic G17,
  output logic G7
);

  // State vector bit order: [2]=G5, [1]=G6, [0]=G7.
  logic [CHAIN_LEN-1:0] w_q;
  logic [CHAIN_LEN-1:0] w_d;
  logic [CHAIN_LEN-1:0] w_si;

  logic w_g5, w_g6, w_g7;
  logic w_g8, w_g9, w_g10, w_g11, w_g12, w_g13, w_g14, w_g15, w_g16;

  assign w_g5 = w_q[2];
  assign w_g6 = w_q[1];
  assign w_g7 = w_q[0];

  // Gate-level s27 core.
  assign w_g14 = ~G0;
  assign w_g8  = w_g14 & w_g6;
  assign w_g12 = ~(G1 | w_g7);
  assign w_g15 = w_g12 | w_g8;
  assign w_g16 = G3 | w_g8;
  assign w_g9  = ~(w_g16 & w_g15);
  assign w_g11 = ~(w_g5 | w_g9);
  assign w_g10 = ~(w_g14 | w_g11);
  assign w_g13 = ~(G2 | w_g12);

  assign G17 = ~w_g11;
  assign G7  = w_g7;

  // Functional next state.
  assign w_d = {w_g10, w_g11, w_g13};

  // Scan path: each flop takes the one above it, the top one takes SI.
  assign w_si = {SI, w_q[CHAIN_LEN-1:1]};

  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_chain
    s27_scan_dff #(
      .RST_VAL (RST_STATE[i])
    ) u_dff (
      .ck_i  (CK),
      .rst_i (RST),
      .se_i  (SE),
      .si_i  (w_si[i]),
      .d_i   (w_d[i]),
      .q_o   (w_q[i])
    );
  end

endmodule : s27_scan
`default_nettype wire

// File: tb/tb_s27_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_s27_scan
// Description : Directed self-checking bench for s27_scan. Expected values
//               are hand-derived from the s27 gate equations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s27_scan;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  logic G0  = 1'b0;
  logic G1  = 1'b0;
  logic G2  = 1'b0;
  logic G3  = 1'b0;
  logic SI  = 1'b0;
  logic SE  = 1'b0;
  logic G17;
  logic G7;

  int total  = 0;
  int passed = 0;

  s27_scan dut (
    .CK  (CK),
    .RST (RST),
    .G0  (G0),
    .G1  (G1),
    .G2  (G2),
    .G3  (G3),
    .SI  (SI),
    .SE  (SE),
    .G17 (G17),
    .G7  (G7)
  );

  always #5 CK = ~CK;

  // Observe the internal state {G5,G6,G7}.
  logic [2:0] st;
  assign st = dut.w_q;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // ---------------- reset state, all-zero inputs --------------------------
    tick();
    tick();
    chk3("reset_state", st, 3'b000);
    chk1("reset_g17", G17, 1'b1);
    RST = 1'b0;
    tick(); tick(); tick();
    chk3("zero_hold_state", st, 3'b000);
    chk1("zero_hold_g7", G7, 1'b0);
    chk1("zero_hold_g17", G17, 1'b1);

    // ---------------- G0=1, G2=1 capture -> 100 ----------------------------
    G0 = 1'b1; G2 = 1'b1;
    tick();
    chk3("cap100_state", st, 3'b100);
    chk1("cap100_g17", G17, 1'b1);
    // SI unknown while SE=0 must not disturb state
    SI = 1'bx;
    tick(); tick();
    chk3("cap100_hold_x_si", st, 3'b100);
    // SE pulsed high between edges has no effect
    SE = 1'b1; #1; SE = 1'b0;
    tick();
    chk3("se_glitch_hold", st, 3'b100);
    SI = 1'b0;

    // ---------------- G3=1 from 000 -> G17=0, next 010 ---------------------
    G0 = 1'b0; G2 = 1'b0;
    do_reset();
    G3 = 1'b1; G1 = 1'b0;
    #1;
    chk1("g3_g17_comb", G17, 1'b0);
    chk3("g3_pre_state", st, 3'b000);
    tick();
    chk3("g3_cap_state", st, 3'b010);
    chk1("g3_after_g17", G17, 1'b0);
    G3 = 1'b0;

    // ---------------- scan shift 1,0,1 then 0,0,0 --------------------------
    do_reset();
    SE = 1'b1;
    SI = 1'b1; tick();
    chk3("shift1", st, 3'b100);
    SI = 1'b0; tick();
    chk3("shift2", st, 3'b010);
    SI = 1'b1; tick();
    chk3("shift3", st, 3'b101);
    chk1("shift3_so", G7, 1'b1);
    SI = 1'b0; tick();
    chk1("shift4_so", G7, 1'b0);
    tick();
    chk1("shift5_so", G7, 1'b1);
    tick();
    chk1("shift6_so", G7, 1'b0);
    chk3("shift6_state", st, 3'b000);

    // ---------------- scan-capture-shift -----------------------------------
    // state is 000 from the scan load above
    SE = 1'b0; G0 = 1'b1; G2 = 1'b1;
    tick();
    chk3("scs_capture", st, 3'b100);
    G0 = 1'b0; G2 = 1'b0;
    SE = 1'b1; SI = 1'b0;
    tick();
    chk3("scs_shift1", st, 3'b010);
    chk1("scs_shift1_so", G7, 1'b0);
    tick();
    chk1("scs_shift2_so", G7, 1'b1);

    // ---------------- async reset mid-shift --------------------------------
    do_reset();
    SE = 1'b1;
    SI = 1'b1; tick();
    SI = 1'b0; tick();
    SI = 1'b1; tick();
    chk3("ar_pre_state", st, 3'b101);
    #1;
    RST = 1'b1;
    #1;
    chk3("ar_async_state", st, 3'b000);
    chk1("ar_async_g7", G7, 1'b0);
    #1;
    RST = 1'b0;
    SI = 1'b1; tick();
    chk3("ar_resume1", st, 3'b100);
    SI = 1'b1; tick();
    chk3("ar_resume2", st, 3'b110);
    SI = 1'b0; tick();
    chk3("ar_resume3", st, 3'b011);
    chk1("ar_resume3_so", G7, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_s27_scan
`default_nettype wire
